// File: rtl/hasti_sram_slave.sv
// hasti_sram_slave: AHB-Lite (HASTI) responder wrapping a word-organised SRAM.
// Byte/halfword/word accesses, programmable wait states, and a two-cycle
// ERROR response for illegal or misaligned transfers.
module hasti_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);
    localparam int unsigned WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic                  dp_valid, dp_valid_nx;
    logic [ADDR_WIDTH-1:0] dp_addr;
    logic                  dp_write;
    logic [2:0]            dp_size;
    logic                  accept, illegal, dp_last, wr_en;
    logic [3:0]            be;
    logic [ADDR_WIDTH-3:0] widx;
    logic [31:0]           mem [WORDS];
    logic                  unused_ok;

    // Burst type, protection, lock and upper address bits carry no meaning here.
    assign unused_ok = ^{hburst, hprot, hmastlock, haddr[31:ADDR_WIDTH]};

    // Address-phase decode: a new transfer is only taken while this slave is ready.
    always_comb begin
        accept  = ((state == S_IDLE) || (state == S_ERR2)) && hsel && hready && htrans[1];
        illegal = (hsize > 3'd2)
               || ((hsize == 3'd1) && haddr[0])
               || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    end

    // Next state, wait counter and data-phase tracking; handshake outputs.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        dp_valid_nx = dp_valid;
        hreadyout   = 1'b1;
        hresp       = 1'b0;
        case (state)
            S_IDLE, S_ERR2: begin
                // Any pending OKAY data phase completes in this cycle.
                hresp       = (state == S_ERR2);
                state_nx    = S_IDLE;
                cnt_nx      = '0;
                dp_valid_nx = 1'b0;
                if (accept) begin
                    if (illegal) begin
                        state_nx = S_ERR1;
                    end else begin
                        dp_valid_nx = 1'b1;
                        if (WS != 4'd0) begin
                            state_nx = S_WAIT;
                            cnt_nx   = WS;
                        end
                    end
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (cnt <= 4'd1) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_ERR1: begin
                hreadyout   = 1'b0;
                hresp       = 1'b1;
                dp_valid_nx = 1'b0;
                state_nx    = S_ERR2;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Data-phase qualifiers, byte-lane enables and read data.
    always_comb begin
        dp_last = dp_valid && (state == S_IDLE);
        wr_en   = dp_last && dp_write && !hreset;
        widx    = dp_addr[ADDR_WIDTH-1:2];
        case (dp_size)
            3'd0:    be = 4'b0001 << dp_addr[1:0];
            3'd1:    be = dp_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        hrdata = (dp_last && !dp_write) ? mem[widx] : '0;
    end

    // State, counter and registered address-phase information.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dp_valid <= 1'b0;
            dp_addr  <= '0;
            dp_write <= 1'b0;
            dp_size  <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            dp_valid <= dp_valid_nx;
            if (accept) begin
                dp_addr  <= haddr[ADDR_WIDTH-1:0];
                dp_write <= hwrite;
                dp_size  <= hsize;
            end
        end
    end

    // Memory array: byte-lane write at the end of the final OKAY data-phase cycle.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_hasti_sram_slave.sv
// Testbench for hasti_sram_slave: two instances (0 and 3 wait states) driven
// from a transfer table; expected data-phase cycles are queued at issue time
// and compared cycle by cycle.
module tb_hasti_sram_slave;
    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0, hwrite = 1'b0, hmastlock = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [2:0]  hsize = 3'd2, hburst = '0;
    logic [3:0]  hprot = '0;
    logic [1:0]  htrans = '0;
    logic        use3 = 1'b0;

    logic        hsel0, hsel3, hro0, hro3, hresp0, hresp3, hro, hrsp;
    logic [31:0] hrdata0, hrdata3, hrd;

    assign hsel0 = hsel & ~use3;
    assign hsel3 = hsel & use3;
    assign hro   = use3 ? hro3 : hro0;
    assign hrsp  = use3 ? hresp3 : hresp0;
    assign hrd   = use3 ? hrdata3 : hrdata0;

    always #5 hclk = ~hclk;

    hasti_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
        .hmastlock(hmastlock), .hwdata(hwdata), .hready(hro0),
        .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0)
    );

    hasti_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
        .hmastlock(hmastlock), .hwdata(hwdata), .hready(hro3),
        .hreadyout(hro3), .hresp(hresp3), .hrdata(hrdata3)
    );

    typedef struct {
        logic        dut3;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        logic        hro;
        logic        hresp;
        logic [31:0] rdata;
        logic        chk_rd;
        int          idx;
    } rec_t;

    xfer_t tbl [28];
    rec_t  exp_q [$];
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic void push_exp(input xfer_t x, input int idx);
        int ws;
        ws = x.dut3 ? 3 : 0;
        if (x.err) begin
            exp_q.push_back('{1'b0, 1'b1, 32'h0, 1'b1, idx});
            exp_q.push_back('{1'b1, 1'b1, 32'h0, 1'b1, idx});
        end else begin
            for (int k = 0; k < ws; k++) exp_q.push_back('{1'b0, 1'b0, 32'h0, 1'b1, idx});
            exp_q.push_back('{1'b1, 1'b0, x.rdata, !x.wr, idx});
        end
    endfunction

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
    endtask

    // Issues table entries lo..hi as a pipelined master and drains the scoreboard.
    task automatic run_seg(input int lo, input int hi);
        int          i;
        logic        have_wd;
        logic [31:0] next_wd;
        rec_t        e;
        i       = lo;
        have_wd = 1'b0;
        next_wd = '0;
        use3    = tbl[lo].dut3;
        while (i <= hi || exp_q.size() != 0) begin
            @(posedge hclk);
            #1;
            if (have_wd) hwdata = next_wd;
            have_wd = 1'b0;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '{1'b1, 1'b0, 32'h0, 1'b1, -1};
            chk("hreadyout", e.idx, {31'b0, hro}, {31'b0, e.hro});
            chk("hresp", e.idx, {31'b0, hrsp}, {31'b0, e.hresp});
            if (e.chk_rd) chk("hrdata", e.idx, hrd, e.rdata);
            if (e.hro) begin
                if (i <= hi) begin
                    hsel   = tbl[i].sel;
                    htrans = tbl[i].trans;
                    hwrite = tbl[i].wr;
                    hsize  = tbl[i].size;
                    haddr  = tbl[i].addr;
                    if (tbl[i].sel && tbl[i].trans[1]) push_exp(tbl[i], i);
                    have_wd = 1'b1;
                    next_wd = tbl[i].wdata;
                    i++;
                end else begin
                    drive_idle();
                end
            end
        end
    endtask

    initial begin
        // dut3 sel trans wr size addr wdata err rdata
        tbl[0]  = '{1'b0, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 2'd3, 1'b0, 3'd2, 32'h0000_0004, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_0000, 32'h1122_3344, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 2'd2, 1'b1, 3'd0, 32'h0000_0001, 32'h0000_AA00, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'h1122_AA44};
        tbl[5]  = '{1'b0, 1'b1, 2'd2, 1'b1, 3'd1, 32'h0000_0002, 32'hBBCC_0000, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'hBBCC_AA44};
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'hBBCC_AA44};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd3, 32'h0000_0000, 32'h0,         1'b1, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 1'b1, 3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 2'd1, 1'b1, 3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 2'd2, 1'b1, 3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'hBBCC_AA44};
        tbl[14] = '{1'b0, 1'b1, 2'd2, 1'b1, 3'd1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 2'd3, 1'b1, 3'd2, 32'h0000_0408, 32'h0000_0055, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0055};
        tbl[17] = '{1'b0, 1'b1, 2'd2, 1'b1, 3'd0, 32'h0000_0003, 32'h7700_0000, 1'b0, 32'h0};
        tbl[18] = '{1'b0, 1'b1, 2'd2, 1'b1, 3'd1, 32'h0000_0000, 32'h0000_1234, 1'b0, 32'h0};
        tbl[19] = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'h77CC_1234};
        tbl[20] = '{1'b0, 1'b1, 2'd3, 1'b0, 3'd0, 32'h0000_0006, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[21] = '{1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_000C, 32'hCAFE_F00D, 1'b0, 32'h0};
        tbl[22] = '{1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_000C, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[23] = '{1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0006, 32'h0,         1'b1, 32'h0};
        tbl[24] = '{1'b1, 1'b1, 2'd2, 1'b0, 3'd0, 32'h0000_000D, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[25] = '{1'b1, 1'b1, 2'd2, 1'b1, 3'd0, 32'h0000_000E, 32'h00AB_0000, 1'b0, 32'h0};
        tbl[26] = '{1'b1, 1'b1, 2'd2, 1'b0, 3'd1, 32'h0000_000E, 32'h0,         1'b0, 32'hCAAB_F00D};
        tbl[27] = '{1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_000C, 32'h0,         1'b0, 32'hCAAB_F00D};

        // Reset state of both instances.
        hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        hreset = 1'b0;
        chk("rst_hreadyout0", 0, {31'b0, hro0}, 32'd1);
        chk("rst_hresp0", 0, {31'b0, hresp0}, 32'd0);
        chk("rst_hrdata0", 0, hrdata0, 32'h0);
        chk("rst_hreadyout3", 0, {31'b0, hro3}, 32'd1);
        chk("rst_hresp3", 0, {31'b0, hresp3}, 32'd0);
        chk("rst_hrdata3", 0, hrdata3, 32'h0);

        run_seg(0, 20);
        run_seg(21, 26);

        // Reset during the second wait cycle of a write discards it.
        use3 = 1'b1;
        @(posedge hclk);
        #1;
        chk("rw_addr_ready", 100, {31'b0, hro}, 32'd1);
        hsel   = 1'b1;
        htrans = 2'd2;
        hwrite = 1'b1;
        hsize  = 3'd2;
        haddr  = 32'h0000_000C;
        @(posedge hclk);
        #1;
        hwdata = 32'h1234_5678;
        chk("rw_wait1", 101, {31'b0, hro}, 32'd0);
        @(posedge hclk);
        #1;
        chk("rw_wait2", 102, {31'b0, hro}, 32'd0);
        hreset = 1'b1;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        drive_idle();
        chk("rw_post_hreadyout", 103, {31'b0, hro}, 32'd1);
        chk("rw_post_hresp", 103, {31'b0, hrsp}, 32'd0);
        chk("rw_post_hrdata", 103, hrd, 32'h0);

        run_seg(27, 27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hasti_sram_slave.md
Name: hasti_sram_slave

Overview:
- HASTI (AHB-Lite) responder: single-port word-organised SRAM behind one slave select of the system bus.
- Sits downstream of the bus decoder/mux. It receives the master's address/control/write data plus the bus-level hready, and returns hrdata, hreadyout and hresp.
- Supports byte, halfword and word accesses and a programmable number of wait states.
- Returns the two-cycle ERROR response for illegal or misaligned transfers.

Parameters:
- ADDR_WIDTH, 10: byte-address bits decoded. Memory is 2**(ADDR_WIDTH-2) 32-bit words. Upper haddr bits are ignored, so accesses alias.
- WAIT_STATES, 0: number of hreadyout=0 cycles inserted in every OKAY data phase (0..15).

Ports:
- hclk, input, 1: clock.
- hreset, input, 1: synchronous, active-high reset.
- hsel, input, 1: slave select from the decoder.
- haddr, input, 32: transfer address.
- hwrite, input, 1: 1 = write.
- hsize, input, 3: 0 = byte, 1 = halfword, 2 = word.
- hburst, input, 3: ignored; every beat is handled independently.
- hprot, input, 4: ignored.
- htrans, input, 2: 0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- hmastlock, input, 1: ignored.
- hwdata, input, 32: write data, valid in the data phase.
- hready, input, 1: bus-level ready; qualifies address-phase sampling.
- hreadyout, output, 1: this slave's data-phase ready.
- hresp, output, 1: 0 = OKAY, 1 = ERROR.
- hrdata, output, 32: read data.

Behaviour:
- Transfer acceptance:
  - A transfer is accepted at a rising edge where hsel=1, hready=1 and htrans[1]=1.
  - On acceptance, register haddr[ADDR_WIDTH-1:0], hwrite and hsize.
  - IDLE/BUSY with hsel=1, or hsel=0: no transfer. The next cycle is zero-wait OKAY.
- Illegal transfer: any of the following is detected at acceptance.
  - hsize>2.
  - hsize=1 with haddr[0]=1.
  - hsize=2 with haddr[1:0]!=0.
- State machine: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. On a legal accept: go to WAIT if WAIT_STATES>0 (load counter with WAIT_STATES), else stay in IDLE and complete the data phase in the next cycle. On an illegal accept: go to ERR1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle. When it reaches 1, go to IDLE. The final (hreadyout=1) data-phase cycle is therefore WAIT_STATES+1 cycles after the address phase.
  - ERR1: hreadyout=0, hresp=1. Unconditionally go to ERR2, independent of htrans/hsel.
  - ERR2: hreadyout=1, hresp=1. A new transfer may be accepted here and is handled as from IDLE. Otherwise go to IDLE.
- Writes:
  - Commit at the edge ending the last data-phase cycle (hreadyout=1, OKAY).
  - Byte lanes are selected by the registered hsize and addr[1:0], little-endian.
  - A byte write to addr[1:0]=k writes hwdata[8k+7:8k] only.
  - A halfword write writes lanes {addr[1],0} and {addr[1],1}.
  - A word write writes all four lanes.
  - Unselected lanes are unchanged.
  - Errored transfers never modify memory.
- Reads:
  - hrdata carries the full 32-bit word at the registered word address during the last data-phase cycle. Unselected lanes return actual memory content.
  - hrdata is 0 in all other cycles, including ERR1/ERR2 and idle.
  - Read-after-write to the same word on consecutive transfers returns the newly written data, with no extra wait state.
- Pipelining: at WAIT_STATES=0, back-to-back NONSEQ/SEQ transfers complete one per cycle.
- Reset:
  - hreadyout=1, hresp=0, hrdata=0, state IDLE, counter 0.
  - Memory contents are not reset.
  - Reset asserted mid data phase (WAIT/ERR1/ERR2) discards the transfer; no memory write.
- Address wrap: haddr=2**ADDR_WIDTH+0x4 accesses word 1.

Test Plan:
- WAIT_STATES=0:
  - Write word 0xDEADBEEF to 0x0004, then read 0x0004 back-to-back -> hreadyout always 1; read data phase hrdata=0xDEADBEEF, hresp=0.
- Byte/halfword writes:
  - Word 0x0 = 0x11223344. Write byte 0xAA at 0x1 (hwdata=0x0000AA00) -> read 0x0 = 0x1122AA44.
  - Then halfword 0xBBCC at 0x2 (hwdata=0xBBCC0000) -> read 0x0 = 0xBBCCAA44.
- WAIT_STATES=3:
  - Read NONSEQ -> hreadyout=0 for exactly 3 cycles, then 1 with valid hrdata; master address held stable and not re-accepted during waits.
- Misaligned word write to 0x0002 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1).
  - Word 0x0 is unchanged.
  - A NONSEQ issued in ERR2 is accepted and completes OKAY.
- hsize=3, and IDLE/BUSY with hsel=1:
  - hsize=3 -> ERROR sequence.
  - IDLE/BUSY with hsel=1 -> zero-wait OKAY, memory unchanged.
- Reset:
  - Assert hreset during the 2nd wait cycle of a write (WAIT_STATES=3) -> next cycle hreadyout=1, hresp=0, hrdata=0; target word retains its old value.
  - Alias check: write 0x55 at 0x400+0x8 (ADDR_WIDTH=10) -> readable at 0x8.
